// File: rtl/pipe_pkg.sv
// Shared pipeline types: fetch FSM encoding and PC constants.
// Used by fetch_ctrl and its stall watchdog.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC = 32'd0;

  function automatic logic [31:0] pc_inc(
    input logic [31:0] pc
  );
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus between ID/hazard logic, the PC register
// and the IF/ID register; fetch_ctrl sits on the slave side.
interface fetch_ctrl_if;

  logic        hd_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] pc_cur_i;
  logic [31:0] pc_next_o;
  logic        pc_hold_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;

  modport master (
    output hd_i,
    output branch_taken_i,
    output branch_target_i,
    output jump_i,
    output jump_target_i,
    output pc_cur_i,
    input  pc_next_o,
    input  pc_hold_o,
    input  if_id_stall_o,
    input  if_id_flush_o
  );

  modport slave (
    input  hd_i,
    input  branch_taken_i,
    input  branch_target_i,
    input  jump_i,
    input  jump_target_i,
    input  pc_cur_i,
    output pc_next_o,
    output pc_hold_o,
    output if_id_stall_o,
    output if_id_flush_o
  );

endinterface

// File: rtl/fetch_stall_wd.sv
// Stall watchdog: counts consecutive load-use stall cycles and
// raises a sticky timeout once the run reaches STALL_MAX.
module fetch_stall_wd
  import pipe_pkg::*;
#(
  parameter int STALL_MAX = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic active_i,
  input  logic idle_i,
  input  logic hd_i,
  output logic timeout_o
);

  localparam logic [7:0] LAST = 8'(STALL_MAX - 1);

  logic [7:0] cnt_q;
  logic       inc;
  logic       clr;

  assign inc = hd_i && active_i;
  assign clr = !hd_i || idle_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timeout_o <= 1'b0;
    end else if (inc && cnt_q == LAST) begin
      timeout_o <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer: PC+4 / branch / jump select, IF/ID stall+flush.
// FETCH_CTRL_PERF_EN adds stall and redirect cycle counters.
module fetch_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int STALL_MAX   = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  fetch_ctrl_if.slave  fif,
  output logic [1:0]   state_o,
  output logic         stall_timeout_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_o,
  output logic [31:0]  perf_redir_o
`endif
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);
  localparam bit MULTI_FLUSH = (FLUSH_DEPTH > 1);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [1:0]   flush_cnt_q;
  logic [1:0]   flush_cnt_d;
  logic         redir;

  logic active;
  logic sel_off;
  logic sel_wake;
  logic sel_hd;
  logic sel_br;
  logic sel_jmp;
  logic sel_seq;

  // One-hot decode of the priority list
  assign active   = start_i && state_q != ST_IDLE;
  assign sel_off  = !start_i;
  assign sel_wake = start_i && state_q == ST_IDLE;
  assign sel_hd   = active && fif.hd_i;
  assign sel_br   = active && !fif.hd_i
                 && fif.branch_taken_i;
  assign sel_jmp  = active && !fif.hd_i
                 && !fif.branch_taken_i && fif.jump_i;
  assign sel_seq  = active && !fif.hd_i
                 && !fif.branch_taken_i && !fif.jump_i;

  always_comb begin
    state_d           = ST_IDLE;
    flush_cnt_d       = flush_cnt_q;
    redir             = 1'b0;
    fif.pc_next_o     = fif.pc_cur_i;
    fif.pc_hold_o     = 1'b1;
    fif.if_id_stall_o = 1'b0;
    fif.if_id_flush_o = 1'b0;
    unique case (1'b1)
      sel_off: begin
        state_d = ST_IDLE;
      end
      sel_wake: begin
        state_d = ST_RUN;
      end
      sel_hd: begin
        fif.if_id_stall_o = 1'b1;
        state_d           = ST_STALL;
      end
      sel_br, sel_jmp: begin
        redir             = 1'b1;
        fif.pc_hold_o     = 1'b0;
        fif.if_id_flush_o = 1'b1;
        fif.pc_next_o     = sel_br ? fif.branch_target_i
                                   : fif.jump_target_i;
        flush_cnt_d       = FLUSH_LOAD;
        state_d           = MULTI_FLUSH ? ST_FLUSH
                                        : ST_RUN;
      end
      sel_seq: begin
        fif.pc_hold_o = 1'b0;
        fif.pc_next_o = pc_inc(fif.pc_cur_i);
        state_d       = ST_RUN;
        if (state_q == ST_FLUSH) begin
          fif.if_id_flush_o = 1'b1;
          flush_cnt_d       = flush_cnt_q - 2'd1;
          if (flush_cnt_q > 2'd1) begin
            state_d = ST_FLUSH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o = state_q;

  fetch_stall_wd #(
    .STALL_MAX (STALL_MAX)
  ) u_wd (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .active_i  (state_q == ST_RUN
             || state_q == ST_STALL),
    .idle_i    (state_q == ST_IDLE),
    .hd_i      (fif.hd_i),
    .timeout_o (stall_timeout_o)
  );

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_stall_o <= '0;
      perf_redir_o <= '0;
    end else begin
      if (fif.pc_hold_o && start_i) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
      if (redir) begin
        perf_redir_o <= perf_redir_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized + directed bench for fetch_ctrl against a
// cycle-level reference model (FLUSH_DEPTH=3, STALL_MAX=4).
module tb_fetch_ctrl;

  localparam int FD = 3;
  localparam int SM = 4;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [1:0]  state_o;
  logic        stall_timeout_o;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_o;
  logic [31:0] perf_redir_o;
`endif

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .FLUSH_DEPTH (FD),
    .STALL_MAX   (SM)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .start_i         (start_i),
    .fif             (bus.slave),
    .state_o         (state_o),
    .stall_timeout_o (stall_timeout_o)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_o    (perf_stall_o),
    .perf_redir_o    (perf_redir_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  int m_state;
  int m_fl;
  int m_run;
  bit m_to;
  int unsigned m_ps;
  int unsigned m_pr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_fl    = 0;
    m_run   = 0;
    m_to    = 1'b0;
    m_ps    = 0;
    m_pr    = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(
    input bit          s,
    input bit          h,
    input bit          b,
    input logic [31:0] bt,
    input bit          j,
    input logic [31:0] jt,
    input logic [31:0] pc
  );
    bit          act;
    bit          rd;
    bit          e_hold;
    bit          e_stall;
    bit          e_flush;
    logic [31:0] e_pc;
    int          ns;
    start_i            = s;
    bus.hd_i           = h;
    bus.branch_taken_i = b;
    bus.branch_target_i = bt;
    bus.jump_i         = j;
    bus.jump_target_i  = jt;
    bus.pc_cur_i       = pc;
    act     = s && m_state != 0;
    rd      = act && !h && (b || j);
    e_hold  = !act || h;
    e_stall = act && h;
    e_flush = rd || (act && !h && m_state == 3);
    if (!act || h)  e_pc = pc;
    else if (b)     e_pc = bt;
    else if (j)     e_pc = jt;
    else            e_pc = pc + 32'd4;
    #3;
    check("pc_next", bus.pc_next_o, e_pc);
    check("pc_hold", 32'(bus.pc_hold_o), 32'(e_hold));
    check("stall", 32'(bus.if_id_stall_o), 32'(e_stall));
    check("flush", 32'(bus.if_id_flush_o), 32'(e_flush));
    check("excl", 32'(bus.if_id_stall_o
                      && bus.if_id_flush_o), 32'd0);
    if (e_hold && s) m_ps++;
    if (rd) m_pr++;
    if (m_state == 0 || !h) begin
      m_run = 0;
    end else if (m_state == 1 || m_state == 2) begin
      if (m_run == SM - 1) m_to = 1'b1;
      if (m_run < 255) m_run++;
    end
    if (!s) begin
      ns = 0;
    end else if (m_state == 0) begin
      ns = 1;
    end else if (h) begin
      ns = 2;
    end else if (rd) begin
      m_fl = FD - 1;
      ns   = (FD > 1) ? 3 : 1;
    end else if (m_state == 3) begin
      m_fl--;
      ns = (m_fl > 0) ? 3 : 1;
    end else begin
      ns = 1;
    end
    m_state = ns;
    @(posedge clk_i);
    #1;
    check("state", 32'(state_o), 32'(m_state));
    check("timeout", 32'(stall_timeout_o), 32'(m_to));
`ifdef FETCH_CTRL_PERF_EN
    check("perf_stall", perf_stall_o, m_ps);
    check("perf_redir", perf_redir_o, m_pr);
`endif
  endtask

  task automatic quiet(input logic [31:0] pc);
    cyc(1, 0, 0, 32'h0, 0, 32'h0, pc);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i             = 1'b0;
    start_i             = 1'b0;
    bus.hd_i            = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = '0;
    bus.jump_i          = 1'b0;
    bus.jump_target_i   = '0;
    bus.pc_cur_i        = 32'h100;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_timeout", 32'(stall_timeout_o), 32'd0);
    check("rst_hold", 32'(bus.pc_hold_o), 32'd1);
    check("rst_pc", bus.pc_next_o, 32'h100);
    rst_n_i = 1'b1;

    // sequential fetch and wrap
    quiet(32'h100);
    quiet(32'h100);
    quiet(32'hFFFF_FFFC);

    // hazard masks branch, then branch redirects
    cyc(1, 1, 1, 32'h40, 0, 32'h0, 32'h104);
    cyc(1, 0, 1, 32'h40, 0, 32'h0, 32'h104);
    quiet(32'h40);
    quiet(32'h44);
    quiet(32'h48);

    // branch beats jump
    cyc(1, 0, 1, 32'h80, 1, 32'h200, 32'h4C);
    quiet(32'h80);
    quiet(32'h84);
    quiet(32'h88);

    // 3-cycle stall must not time out, 4-cycle must
    repeat (3) cyc(1, 1, 0, 32'h0, 0, 32'h0, 32'h8C);
    quiet(32'h8C);
    repeat (4) cyc(1, 1, 0, 32'h0, 0, 32'h0, 32'h90);
    quiet(32'h90);
    quiet(32'h94);

    // async reset mid-RUN with hd asserted
    start_i  = 1'b1;
    bus.hd_i = 1'b1;
    #1;
    rst_n_i = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_timeout", 32'(stall_timeout_o), 32'd0);
    start_i = 1'b0;
    #1;
    check("arst_hold", 32'(bus.pc_hold_o), 32'd1);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          s;
      bit          h;
      bit          b;
      bit          j;
      logic [31:0] pc;
      s  = ($urandom_range(0, 19) != 0);
      h  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 5) == 0);
      j  = ($urandom_range(0, 5) == 0);
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                       : {$urandom()} & ~32'h3;
      cyc(s, h, b, {$urandom()} & ~32'h3, j,
          {$urandom()} & ~32'h3, pc);
      if (i == 200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
